// File: rtl/scytale_if.sv
// scytale_if: character stream, key and status signals of the scytale codec
interface scytale_if #(
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 8
);
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic                 mode_i;
  logic [KEY_WIDTH-1:0] key_N;
  logic [KEY_WIDTH-1:0] key_M;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;
  logic                 busy;
  logic                 err_o;
  modport master (
    output data_i, valid_i, mode_i, key_N, key_M,
    input  data_o, valid_o, busy, err_o
  );
  modport slave (
    input  data_i, valid_i, mode_i, key_N, key_M,
    output data_o, valid_o, busy, err_o
  );
endinterface

// File: rtl/scytale_codec.sv
// scytale_codec: buffers a message, then emits it transposed as an N x M scytale
module scytale_codec #(
  parameter int                   D_WIDTH       = 8,
  parameter int                   KEY_WIDTH     = 8,
  parameter int                   MAX_NOF_CHARS = 50,
  parameter logic [D_WIDTH-1:0]   START_TOKEN   = 8'hFA
) (
  input logic      clk,
  input logic      rst_n,
  scytale_if.slave bus
);
  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_NOF_CHARS);
  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
  state_t state, nxt;
  logic [D_WIDTH-1:0] mem [MAX_NOF_CHARS];
  logic [CW-1:0] count, idx;
  logic [KEY_WIDTH-1:0] n_r, m_r, inner, outer, ilim, olim;
  logic [2*KEY_WIDTH-1:0] prod;
  logic mode_r, accept, tok, ok, store, ovf, wrap, last;
  always_comb begin
    prod = {{KEY_WIDTH{1'b0}}, bus.key_N} * {{KEY_WIDTH{1'b0}}, bus.key_M};
    accept = bus.valid_i && state != EMIT;
    tok = accept && bus.data_i == START_TOKEN;
    ok = bus.key_N != '0 && bus.key_M != '0 &&
         {{CW{1'b0}}, prod} == {{2*KEY_WIDTH{1'b0}}, count};
    store = accept && !tok && count != MAXC;
    ovf = accept && !tok && count == MAXC;
    ilim = mode_r ? n_r : m_r;
    olim = mode_r ? m_r : n_r;
    wrap = inner == ilim - KEY_WIDTH'(1);
    last = wrap && outer == olim - KEY_WIDTH'(1);
    nxt = state == EMIT ? (last ? IDLE : EMIT) :
          tok ? (ok ? EMIT : IDLE) : store ? LOAD : state;
  end
  assign bus.busy = state == EMIT;
  assign bus.valid_o = state == EMIT;
  assign bus.data_o = state == EMIT ? mem[idx] : '0;
  always_ff @(posedge clk) begin
    if (store) mem[count] <= bus.data_i;
  end
  // Read index walks base+k*step with the outer counter as base, so no multiplier is needed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      bus.err_o <= 1'b0;
      mode_r <= 1'b0;
      n_r <= '0;
      m_r <= '0;
      inner <= '0;
      outer <= '0;
      idx <= '0;
    end else begin
      state <= nxt;
      bus.err_o <= (tok && !ok) || ovf;
      if (store) count <= count + CW'(1);
      if (tok) begin
        mode_r <= bus.mode_i;
        n_r <= bus.key_N;
        m_r <= bus.key_M;
        inner <= '0;
        outer <= '0;
        idx <= '0;
        if (!ok) count <= '0;
      end
      if (state == EMIT) begin
        inner <= wrap ? '0 : inner + KEY_WIDTH'(1);
        outer <= wrap ? outer + KEY_WIDTH'(1) : outer;
        idx <= wrap ? CW'(outer + KEY_WIDTH'(1)) : idx + CW'(olim);
        if (last) count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_scytale_codec.sv
// tb_scytale_codec: directed vectors plus corner-case sequences for scytale_codec
module tb_scytale_codec;
  logic clk, rst_n, sel;
  int n_tests, n_fail;
  scytale_if a ();
  scytale_if b ();
  scytale_codec dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  scytale_codec #(.MAX_NOF_CHARS(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
  assign b.data_i = a.data_i;
  assign b.valid_i = a.valid_i;
  assign b.mode_i = a.mode_i;
  assign b.key_N = a.key_N;
  assign b.key_M = a.key_M;
  logic [7:0] d_o;
  logic v_o, bz, er;
  assign d_o = sel ? b.data_o : a.data_o;
  assign v_o = sel ? b.valid_o : a.valid_o;
  assign bz = sel ? b.busy : a.busy;
  assign er = sel ? b.err_o : a.err_o;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    string name;
    bit    mode;
    int    n;
    int    m;
    string din;
    string dout;
  } vec_t;
  vec_t vecs [6];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) begin
      a.valid_i = 1'b1;
      a.data_i = s[i];
      tick();
    end
    a.valid_i = 1'b0;
  endtask
  task automatic token(input bit mode, input int n, input int m);
    a.valid_i = 1'b1;
    a.data_i = 8'hFA;
    a.mode_i = mode;
    a.key_N = n[7:0];
    a.key_M = m[7:0];
    tick();
    a.valid_i = 1'b0;
  endtask
  task automatic idle_chk(input string nm);
    chk({nm, " busy"}, {31'b0, bz}, 0);
    chk({nm, " valid"}, {31'b0, v_o}, 0);
    chk({nm, " data"}, {24'b0, d_o}, 0);
    chk({nm, " err"}, {31'b0, er}, 0);
  endtask
  task automatic expect_out(input string nm, input string exp, input bit noise);
    for (int i = 0; i < exp.len(); i++) begin
      chk($sformatf("%s[%0d] valid", nm, i), {31'b0, v_o}, 1);
      chk($sformatf("%s[%0d] busy", nm, i), {31'b0, bz}, 1);
      chk($sformatf("%s[%0d] data", nm, i), {24'b0, d_o}, {24'b0, exp[i]});
      chk($sformatf("%s[%0d] err", nm, i), {31'b0, er}, 0);
      if (noise) begin
        a.valid_i = 1'b1;
        a.data_i = (i % 2 == 1) ? 8'hFA : 8'h5A;
        a.mode_i = ~a.mode_i;
        a.key_N = 8'd1;
        a.key_M = 8'd1;
      end
      tick();
    end
    a.valid_i = 1'b0;
    idle_chk({nm, " end"});
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    vecs[0] = '{"dec2x3", 1'b0, 2, 3, "ADBECF", "ABCDEF"};
    vecs[1] = '{"enc2x3", 1'b1, 2, 3, "ABCDEF", "ADBECF"};
    vecs[2] = '{"dec1x4", 1'b0, 1, 4, "WXYZ", "WXYZ"};
    vecs[3] = '{"enc4x1", 1'b1, 4, 1, "WXYZ", "WXYZ"};
    vecs[4] = '{"dec3x2", 1'b0, 3, 2, "ABCDEF", "ADBECF"};
    vecs[5] = '{"enc3x2", 1'b1, 3, 2, "ABCDEF", "ACEBDF"};
    sel = 1'b0;
    rst_n = 1'b0;
    a.valid_i = 1'b0;
    a.data_i = '0;
    a.mode_i = 1'b0;
    a.key_N = '0;
    a.key_M = '0;
    repeat (3) tick();
    idle_chk("reset");
    rst_n = 1'b1;
    foreach (vecs[k]) begin
      load(vecs[k].din);
      token(vecs[k].mode, vecs[k].n, vecs[k].m);
      expect_out(vecs[k].name, vecs[k].dout, 1'b0);
    end
    load("ABCDE");
    token(1'b0, 2, 3);
    chk("mismatch err", {31'b0, er}, 1);
    chk("mismatch valid", {31'b0, v_o}, 0);
    chk("mismatch busy", {31'b0, bz}, 0);
    tick();
    chk("mismatch err pulse", {31'b0, er}, 0);
    load("ADBECF");
    token(1'b0, 2, 3);
    expect_out("after_mismatch", "ABCDEF", 1'b0);
    token(1'b0, 0, 3);
    chk("zero key err", {31'b0, er}, 1);
    chk("zero key valid", {31'b0, v_o}, 0);
    tick();
    a.valid_i = 1'b1;
    a.data_i = 8'h00;
    tick();
    a.data_i = 8'h11;
    tick();
    token(1'b0, 1, 2);
    chk("zero char data", {24'b0, d_o}, 0);
    chk("zero char valid", {31'b0, v_o}, 1);
    tick();
    chk("zero char next", {24'b0, d_o}, 32'h11);
    tick();
    idle_chk("zero char end");
    load("ABCDEF");
    token(1'b1, 2, 3);
    expect_out("busy_noise", "ADBECF", 1'b1);
    load("ADBECF");
    token(1'b0, 2, 3);
    chk("rst_emit d0", {24'b0, d_o}, "A");
    tick();
    chk("rst_emit d1", {24'b0, d_o}, "B");
    tick();
    chk("rst_emit d2", {24'b0, d_o}, "C");
    rst_n = 1'b0;
    tick();
    idle_chk("rst_emit");
    rst_n = 1'b1;
    load("ABCDEF");
    token(1'b1, 2, 3);
    expect_out("after_rst", "ADBECF", 1'b0);
    sel = 1'b1;
    load("ABCD");
    chk("ovf no err at 4", {31'b0, er}, 0);
    load("E");
    chk("ovf err", {31'b0, er}, 1);
    tick();
    chk("ovf err pulse", {31'b0, er}, 0);
    token(1'b0, 2, 2);
    expect_out("ovf", "ACBD", 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
